fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the RV32I processor, directly upstream of the main decoder. Holds the program counter, fetches one instruction at a time from instruction memory over a request/response handshake, and presents instruction, PC and PC+4 to decode through a valid/ready output register. Accepts control-flow redirects (branch/jump targets) from execute and discards any fetch in flight when one arrives.

## Interface
- XLEN, 32, datapath and address width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- redirect_valid  in  1  execute requests a PC change this cycle
- redirect_pc  in  XLEN  new PC target
- imem_req  out  1  fetch request
- imem_addr  out  XLEN  fetch address (always current PC)
- imem_ready  in  1  memory accepts request; transfer when imem_req && imem_ready
- imem_rvalid  in  1  response valid, earliest the cycle after acceptance
- imem_rdata  in  32  instruction word
- if_valid  out  1  if_instr/if_pc/if_pc_plus4 valid to decode
- if_ready  in  1  decode consumes; transfer when if_valid && if_ready
- if_instr  out  32  instruction; opcode [6:0] feeds decoder op
- if_pc  out  XLEN  address of if_instr
- if_pc_plus4  out  XLEN  if_pc + 4, link value for JAL/JALR
- if_misaligned  out  1  misaligned-target trap (only with FETCH_MISALIGN_TRAP_EN)

## Operation
- States: IDLE, REQ, WAIT, FULL (plus TRAP when macro defined).
- IDLE: entered on reset; unconditionally → REQ next cycle.
- REQ: imem_req=1, imem_addr=pc. On imem_ready → WAIT. Request may be withdrawn if not accepted; no address-stability requirement before acceptance.
- WAIT: imem_req=0. On imem_rvalid: capture imem_rdata, pc, pc+4 into output register; if_valid=1; → FULL.
- FULL: if_valid=1, no request. On if_ready: pc ← pc+4, if_valid ← 0, → REQ.
- Redirect (any state, priority over everything): pc ← redirect_pc; if_valid ← 0 next cycle.
  - REQ not accepted, or IDLE/FULL → REQ with new pc.
  - WAIT, or REQ with acceptance in the same cycle → set drop flag, stay in/enter WAIT; next imem_rvalid discarded, drop cleared, → REQ.
- Redirect coincident with if_ready in FULL: instruction counts as consumed; pc takes redirect_pc, not pc+4.
- Redirect coincident with imem_rvalid in WAIT: response discarded, → REQ.
- imem_rvalid outside WAIT is ignored.
- pc+4 wraps modulo 2^XLEN.
- Reset values: pc=RESET_PC, state=IDLE, drop=0, imem_req=0, if_valid=0, if_instr=32'h0000_0013 (NOP), if_pc=0, if_pc_plus4=0, if_misaligned=0.
- Reset mid-fetch: all state cleared asynchronously; late responses after reset ignored (state IDLE/REQ).

## Timing
- Reset release at edge 0: IDLE; edge 1: REQ, imem_addr=RESET_PC.
- Zero-wait memory and always-ready decode: one instruction per 3 cycles (REQ, WAIT, FULL).
- Redirect-to-request latency: 1 cycle (imem_addr=redirect_pc in the cycle after redirect_valid).
- Outputs registered; imem_req/imem_addr are decodes of registered state/pc only.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined: redirect_pc[1:0] != 0 → pc loaded, state TRAP, if_misaligned=1, no requests; only another redirect leaves TRAP (if_misaligned cleared, → REQ). If_valid=0 in TRAP.
- Undefined: redirect_pc[1:0] forced to 2'b00; TRAP state absent; if_misaligned tied 0.

## Structure
- Shared package riscv_pkg: XLEN, RESET_PC default, NOP encoding 32'h0000_0013, opcode constants shared with decoder, fetch state enum.
- One sub-module: fetch_pc_gen (pc register, +4 adder, redirect mux, alignment check).

## Test plan
- Reset release, imem_ready=1, rvalid 1 cycle after accept, rdata=32'h0050_0093 → if_valid at cycle 3, if_pc=0, if_pc_plus4=4; next imem_addr=4.
- Decode stalls (if_ready=0 for 5 cycles) → if_* held stable, imem_req=0 throughout; release → imem_addr=4 next cycle.
- Redirect to 32'h0000_0100 while in WAIT, rvalid 2 cycles later with 32'hDEAD_BEEF → response dropped, if_valid stays 0, next imem_addr=32'h100.
- Redirect concurrent with if_ready in FULL → next imem_addr=redirect_pc, not if_pc+4.
- pc=32'hFFFF_FFFC consumed → next imem_addr=0 (wrap).
- With macro: redirect_pc=32'h0000_0102 → if_misaligned=1, imem_req=0 until redirect to 32'h200; without macro: imem_addr=32'h100.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I constants, opcodes and fetch state encoding
package riscv_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        FETCH_IDLE = 3'd0,
        FETCH_REQ  = 3'd1,
        FETCH_WAIT = 3'd2,
        FETCH_FULL = 3'd3
`ifdef FETCH_MISALIGN_TRAP_EN
        , FETCH_TRAP = 3'd4
`endif
    } fetch_state_e;

    function automatic logic low_bits_set(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// rtl/fetch_pc_gen.sv - program counter register, +4 adder, redirect mux, alignment check
module fetch_pc_gen #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            advance,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            misaligned
);
    import riscv_pkg::*;

    logic [XLEN-1:0] target;

    assign pc_plus4 = pc + XLEN'(4);

`ifdef FETCH_MISALIGN_TRAP_EN
    assign target     = redirect_pc;
    assign misaligned = low_bits_set(redirect_pc[1:0]);
`else
    // Without the trap, targets are silently word-aligned.
    assign target     = redirect_pc & ~XLEN'(3);
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= target;
        end else if (advance) begin
            pc <= pc_plus4;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I instruction fetch stage; optional FETCH_MISALIGN_TRAP_EN trap on misaligned redirects
module fetch_stage #(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(riscv_pkg::RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc_plus4,
    output logic            if_misaligned
);
    import riscv_pkg::*;

    fetch_state_e    state;
    logic            drop;
    logic            advance;
    logic            redirect_misaligned;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;

    assign advance   = (state == FETCH_FULL) && if_ready;
    assign imem_req  = (state == FETCH_REQ);
    assign imem_addr = pc;

    fetch_pc_gen #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .advance        (advance),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .misaligned     (redirect_misaligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= FETCH_IDLE;
            drop          <= 1'b0;
            if_valid      <= 1'b0;
            if_instr      <= NOP_INSTR;
            if_pc         <= '0;
            if_pc_plus4   <= '0;
            if_misaligned <= 1'b0;
        end else if (redirect_valid) begin
            if_valid      <= 1'b0;
            if_misaligned <= redirect_misaligned;
            if (redirect_misaligned) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                state <= FETCH_TRAP;
                drop  <= 1'b0;
`endif
            end else if ((state == FETCH_WAIT && !imem_rvalid) ||
                         (state == FETCH_REQ && imem_ready)) begin
                // A fetch is outstanding: swallow its response before refetching.
                state <= FETCH_WAIT;
                drop  <= 1'b1;
            end else begin
                state <= FETCH_REQ;
                drop  <= 1'b0;
            end
        end else begin
            case (state)
                FETCH_IDLE: state <= FETCH_REQ;
                FETCH_REQ: begin
                    if (imem_ready) begin
                        state <= FETCH_WAIT;
                    end
                end
                FETCH_WAIT: begin
                    if (imem_rvalid) begin
                        if (drop) begin
                            drop  <= 1'b0;
                            state <= FETCH_REQ;
                        end else begin
                            if_instr    <= imem_rdata;
                            if_pc       <= pc;
                            if_pc_plus4 <= pc_plus4;
                            if_valid    <= 1'b1;
                            state       <= FETCH_FULL;
                        end
                    end
                end
                FETCH_FULL: begin
                    if (if_ready) begin
                        if_valid <= 1'b0;
                        state    <= FETCH_REQ;
                    end
                end
`ifdef FETCH_MISALIGN_TRAP_EN
                FETCH_TRAP: state <= FETCH_TRAP;
`endif
                default: state <= FETCH_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage with a behavioural memory and PC-stream model
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        if_misaligned;

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;

    logic [31:0] exp_pc;
    logic        pending;
    int unsigned cnt;
    logic [31:0] maddr;
    int unsigned mem_lat;
    logic        spurious_en;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4),
        .if_misaligned  (if_misaligned)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic logic [31:0] redirect_target(input logic [31:0] t);
`ifdef FETCH_MISALIGN_TRAP_EN
        return t;
`else
        return {t[31:2], 2'b00};
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset();
        chk("rst_imem_req", {31'b0, imem_req}, 32'h0);
        chk("rst_if_valid", {31'b0, if_valid}, 32'h0);
        chk("rst_if_instr", if_instr, 32'h0000_0013);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_pc_plus4", if_pc_plus4, 32'h0);
        chk("rst_if_misaligned", {31'b0, if_misaligned}, 32'h0);
    endtask

    // One clock: observe handshakes at negedge, then update the model and memory after the edge.
    task automatic cycle();
        logic acc, con, red, rv_now;
        logic [31:0] acc_addr, red_pc;
        @(negedge clk);
        acc      = rst_n && imem_req && imem_ready;
        con      = rst_n && if_valid && if_ready;
        red      = rst_n && redirect_valid;
        red_pc   = redirect_pc;
        rv_now   = imem_rvalid;
        acc_addr = imem_addr;
        if (acc) begin
            chk("req_addr", acc_addr, exp_pc);
            chk("no_overlap", {31'b0, pending}, 32'h0);
        end
        if (con) begin
            chk("out_pc", if_pc, exp_pc);
            chk("out_pc_plus4", if_pc_plus4, exp_pc + 32'd4);
            chk("out_instr", if_instr, mem_word(exp_pc));
        end
        @(posedge clk);
        #1;
        if (red) begin
            exp_pc = redirect_target(red_pc);
            chk("valid_after_redirect", {31'b0, if_valid}, 32'h0);
        end else if (con) begin
            exp_pc = exp_pc + 32'd4;
        end
        redirect_valid = 1'b0;
        if (pending && rv_now) pending = 1'b0;
        else if (pending && cnt != 0) cnt--;
        if (acc) begin
            pending = 1'b1;
            maddr   = acc_addr;
            cnt     = (mem_lat == 0) ? $urandom_range(0, 2) : mem_lat - 1;
        end
        if (pending && cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(maddr);
        end else if (!pending && spurious_en && $urandom_range(0, 7) == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = $urandom;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_ready     = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        if_ready       = 1'b0;
        exp_pc         = 32'h0;
        pending        = 1'b0;
        cnt            = 0;
        maddr          = 32'h0;
        mem_lat        = 1;
        spurious_en    = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk_reset();
        rst_n = 1'b1;

        // First fetch after reset, then decode stall
        imem_ready = 1'b1;
        cycle();
        chk("first_req", {31'b0, imem_req}, 32'h1);
        chk("first_addr", imem_addr, 32'h0);
        cycle();
        chk("wait_no_valid", {31'b0, if_valid}, 32'h0);
        cycle();
        chk("first_valid", {31'b0, if_valid}, 32'h1);
        chk("first_pc", if_pc, 32'h0);
        chk("first_pc_plus4", if_pc_plus4, 32'h4);
        chk("first_instr", if_instr, 32'h0050_0093);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("stall_valid", {31'b0, if_valid}, 32'h1);
            chk("stall_pc", if_pc, 32'h0);
            chk("stall_instr", if_instr, 32'h0050_0093);
            chk("stall_no_req", {31'b0, imem_req}, 32'h0);
        end
        if_ready = 1'b1;
        cycle();
        chk("release_req", {31'b0, imem_req}, 32'h1);
        chk("release_addr", imem_addr, 32'h4);

        // Redirect while waiting on a response
        if_ready = 1'b0;
        mem_lat  = 3;
        cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        cycle();
        chk("wait_redir_no_req", {31'b0, imem_req}, 32'h0);
        cycle();
        chk("drop_pending_no_req", {31'b0, imem_req}, 32'h0);
        cycle();
        chk("drop_no_valid", {31'b0, if_valid}, 32'h0);
        chk("drop_then_req", {31'b0, imem_req}, 32'h1);
        chk("drop_then_addr", imem_addr, 32'h0000_0100);

        // Redirect coincident with consumption
        mem_lat = 1;
        cycle();
        cycle();
        chk("full_pc_100", if_pc, 32'h0000_0100);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        if_ready       = 1'b1;
        cycle();
        chk("redir_consume_req", {31'b0, imem_req}, 32'h1);
        chk("redir_consume_addr", imem_addr, 32'h0000_0040);

        // PC wrap at the top of the address space
        imem_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        cycle();
        chk("wrap_req_addr", imem_addr, 32'hFFFF_FFFC);
        imem_ready = 1'b1;
        cycle();
        cycle();
        chk("wrap_pc_plus4", if_pc_plus4, 32'h0);
        cycle();
        chk("wrap_next_addr", imem_addr, 32'h0);

        // Misaligned redirect target
        imem_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        cycle();
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("trap_flag", {31'b0, if_misaligned}, 32'h1);
        chk("trap_no_req", {31'b0, imem_req}, 32'h0);
        imem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("trap_hold_no_req", {31'b0, imem_req}, 32'h0);
            chk("trap_hold_flag", {31'b0, if_misaligned}, 32'h1);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        cycle();
        chk("trap_exit_flag", {31'b0, if_misaligned}, 32'h0);
        chk("trap_exit_req", {31'b0, imem_req}, 32'h1);
        chk("trap_exit_addr", imem_addr, 32'h0000_0200);
`else
        chk("align_req", {31'b0, imem_req}, 32'h1);
        chk("align_addr", imem_addr, 32'h0000_0100);
        chk("align_no_flag", {31'b0, if_misaligned}, 32'h0);
`endif

        // Reset in the middle of a fetch; the late response must be ignored
        imem_ready = 1'b1;
        mem_lat    = 3;
        cycle();
        rst_n  = 1'b0;
        #1;
        chk_reset();
        exp_pc     = 32'h0;
        imem_ready = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();
        cycle();
        chk("post_reset_req", {31'b0, imem_req}, 32'h1);
        chk("post_reset_addr", imem_addr, 32'h0);
        chk("post_reset_no_valid", {31'b0, if_valid}, 32'h0);

        // Randomized traffic against the PC-stream model
        mem_lat     = 0;
        spurious_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            imem_ready = ($urandom_range(0, 3) != 0);
            if_ready   = ($urandom_range(0, 2) != 0);
            if (pending) imem_ready = 1'b0;
            if ($urandom_range(0, 15) == 0) begin
                redirect_valid = 1'b1;
                case ($urandom_range(0, 3))
                    0:       redirect_pc = 32'hFFFF_FFF8;
                    1:       redirect_pc = {20'h0, $urandom_range(0, 4095)};
                    default: redirect_pc = $urandom;
                endcase
`ifdef FETCH_MISALIGN_TRAP_EN
                redirect_pc[1:0] = 2'b00;
`endif
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
